// File: rtl/matrix_tx.sv
// Serialises a 16x16 LED frame row by row onto a 3-wire shift-register bus (sclk, sdo, latch).
// Optional MATRIX_TX_ROWADDR_EN prefixes each row with its 4-bit row address, MSB first.
module matrix_tx #(
   parameter int CLK_DIV = 2,
   parameter int ROWS    = 16,
   parameter int COLS    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [ROWS*COLS-1:0] matrix,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 sclk,
   output logic                 sdo,
   output logic                 latch
);

`ifdef MATRIX_TX_ROWADDR_EN
   localparam int ADDR_BITS = 4;
`else
   localparam int ADDR_BITS = 0;
`endif
   localparam int ROW_BITS = COLS + ADDR_BITS;
   localparam int BIT_W    = $clog2(ROW_BITS);
   localparam int ROW_W    = $clog2(ROWS);

   localparam logic [7:0]       DIV_LOAD = 8'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(ROW_BITS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

   typedef enum logic [2:0] {
      IDLE,
      SHIFT_LO,
      SHIFT_HI,
      LATCH,
      DONE
   } state_t;

   state_t                 state_reg, state_next;
   logic [7:0]             cnt_reg, cnt_next;
   logic [ROW_W-1:0]       row_reg, row_next;
   logic [BIT_W-1:0]       bit_reg, bit_next;
   logic [ROWS*COLS-1:0]   shadow_reg, shadow_next;

   logic busy_reg, busy_next;
   logic done_reg, done_next;
   logic sclk_reg, sclk_next;
   logic sdo_reg, sdo_next;
   logic latch_reg, latch_next;

   // Row view of the frame that will be in the shadow register after this edge.
   logic [COLS-1:0] row_words [ROWS];

   genvar gi;
   generate
      for (gi = 0; gi < ROWS; gi++) begin : g_rows
         assign row_words[gi] = shadow_next[gi*COLS +: COLS];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg  <= IDLE;
         cnt_reg    <= 8'd0;
         row_reg    <= '0;
         bit_reg    <= '0;
         shadow_reg <= '0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
         sclk_reg   <= 1'b0;
         sdo_reg    <= 1'b0;
         latch_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         row_reg    <= row_next;
         bit_reg    <= bit_next;
         shadow_reg <= shadow_next;
         busy_reg   <= busy_next;
         done_reg   <= done_next;
         sclk_reg   <= sclk_next;
         sdo_reg    <= sdo_next;
         latch_reg  <= latch_next;
      end
   end

   // Next-state logic; every phase lasts CLK_DIV cycles, counted down from CLK_DIV-1.
   always_comb begin
      state_next  = state_reg;
      cnt_next    = (cnt_reg != 8'd0) ? cnt_reg - 8'd1 : cnt_reg;
      row_next    = row_reg;
      bit_next    = bit_reg;
      shadow_next = shadow_reg;

      case (state_reg)
         IDLE, DONE: begin
            if (start) begin
               shadow_next = matrix;
               row_next    = '0;
               bit_next    = BIT_TOP;
               cnt_next    = DIV_LOAD;
               state_next  = SHIFT_LO;
            end else begin
               state_next  = IDLE;
            end
         end

         SHIFT_LO: begin
            if (cnt_reg == 8'd0) begin
               cnt_next   = DIV_LOAD;
               state_next = SHIFT_HI;
            end
         end

         SHIFT_HI: begin
            if (cnt_reg == 8'd0) begin
               cnt_next = DIV_LOAD;
               if (bit_reg != '0) begin
                  bit_next   = bit_reg - 1'b1;
                  state_next = SHIFT_LO;
               end else begin
                  state_next = LATCH;
               end
            end
         end

         LATCH: begin
            if (cnt_reg == 8'd0) begin
               cnt_next = DIV_LOAD;
               if (row_reg != ROW_LAST) begin
                  row_next   = row_reg + 1'b1;
                  bit_next   = BIT_TOP;
                  state_next = SHIFT_LO;
               end else begin
                  state_next = DONE;
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so every pin comes straight from a flop.
   always_comb begin
      busy_next  = (state_next == SHIFT_LO) || (state_next == SHIFT_HI) || (state_next == LATCH);
      done_next  = (state_next == DONE);
      sclk_next  = (state_next == SHIFT_HI);
      latch_next = (state_next == LATCH);
      sdo_next   = 1'b0;
      if ((state_next == SHIFT_LO) || (state_next == SHIFT_HI)) begin
`ifdef MATRIX_TX_ROWADDR_EN
         if (bit_next >= BIT_W'(COLS)) begin
            sdo_next = row_next[bit_next[1:0]];
         end else begin
            sdo_next = row_words[row_next][bit_next[3:0]];
         end
`else
         sdo_next = row_words[row_next][bit_next];
`endif
      end
   end

   assign busy  = busy_reg;
   assign done  = done_reg;
   assign sclk  = sclk_reg;
   assign sdo   = sdo_reg;
   assign latch = latch_reg;

endmodule

// File: tb/tb_matrix_tx.sv
// Directed bench for matrix_tx: reset, single pixel, snapshot, ignored start, back-to-back, abort.
// Also covers the MATRIX_TX_ROWADDR_EN build (row address prefix, CLK_DIV=1).
module tb_matrix_tx;

`ifdef MATRIX_TX_ROWADDR_EN
   localparam int DIV      = 1;
   localparam int ROW_BITS = 20;
   localparam logic [31:0] EXP_ROW5_ZERO = 32'h0005_0000;
`else
   localparam int DIV      = 2;
   localparam int ROW_BITS = 16;
   localparam logic [31:0] EXP_ROW5_ZERO = 32'h0000_0000;
`endif
   localparam int FRAME = 16 * (2 * ROW_BITS + 1) * DIV;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic [255:0] matrix = '0;
   logic         busy, done, sclk, sdo, latch;

   matrix_tx #(.CLK_DIV(DIV), .ROWS(16), .COLS(16)) dut (
      .clk    (clk),
      .reset  (reset),
      .matrix (matrix),
      .start  (start),
      .busy   (busy),
      .done   (done),
      .sclk   (sclk),
      .sdo    (sdo),
      .latch  (latch)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Bus monitor state, sampled on falling edges.
   int   cyc = 0;
   int   busy_rise_cyc = 0;
   int   done_cnt = 0;
   int   done_lat = -1;
   int   lat_cnt = 0;
   int   lat_w = 0;
   int   lat_bad = 0;
   bit   clr_req = 1'b0;
   logic busy_q = 1'b0, sclk_q = 1'b0, latch_q = 1'b0;
   logic bitq[$];

   always @(negedge clk) begin
      cyc++;
      if (clr_req) begin
         done_cnt = 0;
         done_lat = -1;
         lat_cnt  = 0;
         lat_w    = 0;
         lat_bad  = 0;
         bitq.delete();
      end else begin
         if (busy === 1'b1 && busy_q !== 1'b1) busy_rise_cyc = cyc;
         if (sclk === 1'b1 && sclk_q !== 1'b1) bitq.push_back(sdo);
         if (latch === 1'b1) begin
            lat_w++;
         end else if (latch_q === 1'b1) begin
            lat_cnt++;
            if (lat_w != DIV) lat_bad++;
            lat_w = 0;
         end
         if (done === 1'b1) begin
            done_cnt++;
            done_lat = cyc - busy_rise_cyc;
         end
      end
      busy_q  = busy;
      sclk_q  = sclk;
      latch_q = latch;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_stats();
      clr_req = 1'b1;
      @(negedge clk);
      #1 clr_req = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      while (done !== 1'b1 && k < FRAME + 100) begin
         @(negedge clk);
         k++;
      end
      check(tag, {31'd0, done === 1'b1}, 32'd1);
   endtask

   function automatic logic [31:0] row_word(input int r);
      logic [31:0] w = '0;
      for (int k = 0; k < ROW_BITS; k++) begin
         if (r * ROW_BITS + k >= bitq.size()) return 32'hFFFF_FFFF;
         w = (w << 1) | 32'(bitq[r * ROW_BITS + k]);
      end
      return w;
   endfunction

   function automatic logic [31:0] exp_row(input logic [255:0] mat, input int r);
      logic [15:0] d = mat[r*16 +: 16];
      logic [3:0]  a = 4'(r);
`ifdef MATRIX_TX_ROWADDR_EN
      return {12'd0, a, d};
`else
      return {16'd0, d} | (32'(a) & 32'd0);
`endif
   endfunction

   task automatic check_frame(input string tag, input logic [255:0] mat);
      int bad = 0;
      for (int r = 0; r < 16; r++)
         if (row_word(r) !== exp_row(mat, r)) bad++;
      check({tag, "_bits"}, bitq.size(), 16 * ROW_BITS);
      check({tag, "_rows"}, bad, 0);
      check({tag, "_latches"}, lat_cnt, 16);
      check({tag, "_latch_width"}, lat_bad, 0);
   endtask

   initial begin
      // Reset held with start asserted: everything stays quiet.
      reset  = 1'b0;
      start  = 1'b1;
      matrix = '1;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         check("rst_hold", {27'd0, busy, done, sclk, sdo, latch}, 32'd0);
         @(negedge clk);
      end
      reset  = 1'b1;
      start  = 1'b0;
      matrix = '0;
      tick(3);
      check("idle_outs", {27'd0, busy, done, sclk, sdo, latch}, 32'd0);

      // Single pixel at x=0,y=0.
      matrix = 256'd1;
      clear_stats();
      pulse_start();
      wait_done("sp_done_seen");
      check("sp_done_busy", {31'd0, busy}, 32'd0);
      tick(2);
      check("sp_latency", done_lat, FRAME);
      check("sp_row0", row_word(0), 32'h0000_0001);
      check_frame("sp", 256'd1);
      check("sp_done_count", done_cnt, 1);

      // Snapshot: matrix cleared one cycle after start.
      clear_stats();
      matrix = '1;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      matrix = '0;
      wait_done("snap_done_seen");
      tick(2);
      check_frame("snap", '1);

      // Start pulsed mid-frame is ignored.
      matrix = 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_A5A5_5A5A_0F0F_F0F0_8001_7FFE_C3C3_3C3C;
      clear_stats();
      pulse_start();
      tick(99);
      pulse_start();
      wait_done("ign_done_seen");
      tick(40);
      check("ign_done_count", done_cnt, 1);
      check("ign_busy_after", {31'd0, busy}, 32'd0);
      check_frame("ign", 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_A5A5_5A5A_0F0F_F0F0_8001_7FFE_C3C3_3C3C);

      // Back-to-back with start held, then abort the second frame.
      matrix = '0;
      clear_stats();
      start = 1'b1;
      wait_done("b2b_done_seen");
      check("b2b_done_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("b2b_busy_next", {31'd0, busy}, 32'd1);
      start = 1'b0;
      tick(299);
      check("pre_abort_busy", {31'd0, busy}, 32'd1);
      reset   = 1'b0;
      clr_req = 1'b1;
      @(negedge clk);
      check("abort_outs", {27'd0, busy, done, sclk, sdo, latch}, 32'd0);
      #1 clr_req = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      tick(FRAME + 20);
      check("abort_no_done", done_cnt, 0);
      check("abort_no_latch", lat_cnt, 0);
      check("abort_no_bits", bitq.size(), 0);

      // All-zero frame: row 5 carries only its address when the prefix is built in.
      matrix = '0;
      clear_stats();
      pulse_start();
      wait_done("zero_done_seen");
      tick(2);
      check("zero_latency", done_lat, FRAME);
      check("zero_row5", row_word(5), EXP_ROW5_ZERO);
      check_frame("zero", '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
